coffee_brew_ctrl: RTL

Coffee-machine control FSM that sits directly upstream of the 7-segment display decoder. It accepts coin and drink-select pulses, tracks credit, runs a timed brew countdown, and refunds change. It drives the 4-bit Seg digit that the decoder turns into the status digit. Values 0-9 are digits; 4'hF is outside the decoder's valid range, so the display shows a dash.

---
 rtl/coffee_brew_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/coffee_brew_ctrl.sv
// rtl/coffee_brew_ctrl.sv - coffee machine credit/brew/refund FSM driving the status digit
// All outputs are registered from the next-state values, so each one shows the sampled inputs one cycle later.
module coffee_brew_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int PRICE_SMALL = 2,
  parameter int PRICE_LARGE = 3,
  parameter int BREW_SMALL  = 3,
  parameter int BREW_LARGE  = 5
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Coin,
  input  logic       Sel_small,
  input  logic       Sel_large,
  input  logic       Cancel,
  output logic [3:0] Seg,
  output logic       Brewing,
  output logic       Change,
  output logic       Coin_reject,
  output logic       Low_credit,
  output logic       Done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CREDIT = 3'd1;
  localparam logic [2:0] S_BREW   = 3'd2;
  localparam logic [2:0] S_CHANGE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int              DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]      P_SMALL  = 4'(PRICE_SMALL);
  localparam logic [3:0]      P_LARGE  = 4'(PRICE_LARGE);
  localparam logic [3:0]      T_SMALL  = 4'(BREW_SMALL);
  localparam logic [3:0]      T_LARGE  = 4'(BREW_LARGE);

  logic [2:0]       state, state_n;
  logic [3:0]       credit, credit_n;
  logic [3:0]       count, count_n;
  logic [DIV_W-1:0] div, div_n;
  logic             phase, phase_n;
  logic             change_n, reject_n, low_n;
  logic             coin_ok;
  logic [3:0]       coin_add;
  logic [3:0]       price, brew_time;
  logic [3:0]       seg_n;

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    count_n   = count;
    div_n     = div;
    phase_n   = phase;
    change_n  = 1'b0;
    low_n     = 1'b0;
    price     = Sel_large ? P_LARGE : P_SMALL;
    brew_time = Sel_large ? T_LARGE : T_SMALL;
    coin_ok   = Coin && (credit != 4'd9) && ((state == S_IDLE) || (state == S_CREDIT));
    reject_n  = Coin && !coin_ok;
    coin_add  = credit + {3'b000, coin_ok};

    case (state)
      S_IDLE, S_CREDIT: begin
        credit_n = coin_add;
        if (Cancel) begin
          if (coin_add != 4'd0) begin
            state_n = S_CHANGE;
            phase_n = 1'b0;
          end
        end else if (Sel_large || Sel_small) begin
          // price is checked against the credit held before any same-cycle coin
          if (credit >= price) begin
            credit_n = coin_add - price;
            count_n  = brew_time;
            div_n    = '0;
            state_n  = S_BREW;
          end else begin
            low_n = 1'b1;
          end
        end
        if ((state_n == S_IDLE) || (state_n == S_CREDIT))
          state_n = (credit_n == 4'd0) ? S_IDLE : S_CREDIT;
      end
      S_BREW: begin
        if (count == 4'd0) begin
          state_n = (credit != 4'd0) ? S_CHANGE : S_DONE;
          div_n   = '0;
          phase_n = 1'b0;
        end else if (div == DIV_LAST) begin
          div_n   = '0;
          count_n = count - 4'd1;
        end else begin
          div_n = div + 1'b1;
        end
      end
      S_CHANGE: begin
        // phase 0 emits a unit, phase 1 is the low gap before the next one
        if (!phase) begin
          change_n = 1'b1;
          credit_n = credit - 4'd1;
          phase_n  = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (credit == 4'd0) begin
            state_n = S_DONE;
            div_n   = '0;
          end
        end
      end
      S_DONE: begin
        if (div == DIV_LAST) begin
          state_n = S_IDLE;
          div_n   = '0;
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_BREW:  seg_n = count_n;
      S_DONE:  seg_n = 4'hF;
      default: seg_n = credit_n;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= S_IDLE;
      credit      <= 4'd0;
      count       <= 4'd0;
      div         <= '0;
      phase       <= 1'b0;
      Seg         <= 4'd0;
      Brewing     <= 1'b0;
      Change      <= 1'b0;
      Coin_reject <= 1'b0;
      Low_credit  <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      count       <= count_n;
      div         <= div_n;
      phase       <= phase_n;
      Seg         <= seg_n;
      Brewing     <= (state_n == S_BREW);
      Change      <= change_n;
      Coin_reject <= reject_n;
      Low_credit  <= low_n;
      Done        <= (state_n == S_DONE);
    end
  end

endmodule
